// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared state encoding and defaults for the cpu step controller
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } step_state_t;

  localparam int DEBOUNCE_CYC_DEF = 250000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - front-panel button synchronizer and debouncer with press pulse
module btn_debounce
  import synth_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          b1;
  logic          b2;
  logic [CW-1:0] cnt;

  // A level that flips back before CNT_LAST matches btn_db again, which restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1     <= 1'b0;
      b2     <= 1'b0;
      cnt    <= '0;
      btn_db <= 1'b0;
      press  <= 1'b0;
    end else begin
      b1    <= btn;
      b2    <= b1;
      press <= 1'b0;
      if (b2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        btn_db <= b2;
        press  <= b2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - converts divider edges into cpu_en strobes with run/step/halt control
module cpu_step_ctrl
  import synth_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             halt,
  input  logic             resume,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic [1:0]       state
);

  logic        s1, s2, s3;
  logic        tick;
  logic        btn_db;
  logic        press;
  logic        step_press;
  logic        step_req;
  logic        en_nxt;
  logic        clr_req;
  step_state_t cur;
  step_state_t state_nxt;

  // div_clk is treated purely as data; tick marks a rising edge two samples back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .btn_db(btn_db),
    .press (press)
  );

  assign step_press = press & btn_db;

  always_comb begin
    state_nxt = cur;
    en_nxt    = 1'b0;
    clr_req   = 1'b0;
    case (cur)
      IDLE: begin
        if (halt) begin
          state_nxt = HALTED;
          clr_req   = 1'b1;
        end else if (run_mode) begin
          state_nxt = RUN;
        end else if (step_req) begin
          state_nxt = STEP;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = HALTED;
          clr_req   = 1'b1;
        end else begin
          en_nxt = tick;
          if (!run_mode) state_nxt = IDLE;
        end
      end
      STEP: begin
        if (halt) begin
          state_nxt = HALTED;
          clr_req   = 1'b1;
        end else if (tick) begin
          en_nxt    = 1'b1;
          clr_req   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HALTED: begin
        clr_req = 1'b1;
        if (resume && !halt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A press landing in the same cycle the request is consumed or cleared is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= IDLE;
      cpu_en   <= 1'b0;
      step_req <= 1'b0;
      step_cnt <= '0;
    end else begin
      cur    <= state_nxt;
      cpu_en <= en_nxt;
      if (clr_req) step_req <= 1'b0;
      else if (step_press) step_req <= 1'b1;
      if (cpu_en) step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  assign state = cur;

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Sits directly downstream of the clock divider and upstream of the processor datapath.
- Samples the divider's slow square wave as data in the fast `clk` domain and converts each rising edge into a one-cycle `cpu_en` strobe.
- Provides free-run, single-step (debounced pushbutton) and halt/resume control, plus a retired-step counter for display.

Parameters:
- DEBOUNCE_CYC, 250000, consecutive `clk` cycles a synchronized button level must hold before it is accepted (bench uses 4).
- CNT_W, 32, width of `step_cnt`.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- div_clk  in  1  slow square wave from the divider; sampled as data, never used as a clock.
- run_mode  in  1  1 = free-run, 0 = single-step.
- step_btn  in  1  raw, bouncy pushbutton.
- halt  in  1  level; processor requests stop.
- resume  in  1  pulse; leave HALTED.
- cpu_en  out  1  one-cycle enable for the processor.
- step_cnt  out  CNT_W  count of `cpu_en` pulses issued.
- state  out  2  IDLE=0, RUN=1, STEP=2, HALTED=3.

Behaviour:
- Reset (async, any time): all flops clear, `cpu_en`=0, `step_cnt`=0, `state`=IDLE, pending step request cleared. `cpu_en` drops immediately, without waiting for a clock edge.
- div_clk path:
  - Sync chain s1→s2→s3; tick = s2 & ~s3.
  - First edge sampling `div_clk`=1 is E1. `tick` is high between E2 and E3. A registered `cpu_en` is high from E3 to E4.
  - Latency is 3 edges; `cpu_en` is exactly one cycle wide.
- Input constraint: `div_clk` high and low phases are each ≥3 `clk` cycles, so `cpu_en` is never high on consecutive cycles.
- Button path:
  - 2-flop sync, then debounce counter. The counter resets whenever the synced level equals `btn_db` or changes.
  - When a differing level has been stable for DEBOUNCE_CYC cycles, `btn_db` takes it.
  - A rising edge of `btn_db` sets `step_req`. `step_req` holds at most one pending request; extra presses while pending are dropped.
- FSM, evaluated each cycle; halt has highest priority in every state:
  - IDLE: halt → HALTED; else run_mode → RUN; else step_req → STEP.
  - RUN: on tick, issue `cpu_en`. halt → HALTED, with no `cpu_en` issued for a tick in that same cycle. !run_mode → IDLE.
  - STEP: wait for next tick. On tick, issue one `cpu_en`, clear `step_req`, → IDLE. halt before tick → HALTED, clear `step_req`.
  - HALTED: no `cpu_en`. `step_req` is held clear, so presses are discarded. resume & !halt → IDLE. resume & halt → stay HALTED.
- Mode switch: run_mode 1→0 in RUN returns to IDLE. A `step_req` already pending is honoured from IDLE on the next cycle.
- step_cnt:
  - Increments in the cycle `cpu_en` is high; visible one cycle later.
  - Wraps from all-ones to 0, with no flag.
- `state` reflects the registered FSM state; no combinational path from inputs to `state` or `cpu_en`.

Decomposition:
- Shared package `synth_pkg`:
  - state enum (IDLE/RUN/STEP/HALTED, 2-bit encoding as above)
  - DEBOUNCE_CYC default constant
- One sub-module, `btn_debounce`: sync plus counter, outputs `btn_db` and a one-cycle `press` pulse. Reused later for other front-panel buttons.
- Edge sync for `div_clk` and the FSM stay inline.

Test Plan:
- Reset then run_mode=1, `div_clk` period 8 `clk` (4 high/4 low) for 64 cycles → 8 `cpu_en` pulses, each 1 cycle wide, first on E3 after first high sample; `step_cnt`=8.
- run_mode=0, DEBOUNCE_CYC=4: `step_btn` bounces 1/0/1/0 at 1-cycle intervals, then held high 10 cycles → exactly one `cpu_en` on the next `div_clk` tick; `step_cnt` 0→1; `state` STEP→IDLE.
- RUN with halt asserted in the same cycle as tick → no `cpu_en` that cycle, `state`=3. Pulse resume with halt=0 → IDLE, then RUN, and pulses resume on the next tick.
- HALTED: press button, then resume → `state`=IDLE and no `cpu_en` (press discarded). halt & resume together → stays 3.
- CNT_W=4: run 17 ticks → `step_cnt` sequence reaches 15, wraps to 0, ends at 1.
- Assert `rst` asynchronously mid-RUN while `cpu_en`=1 → `cpu_en`, `step_cnt`, `state` all 0 before the next `clk` edge. After release, the first `cpu_en` needs a fresh `div_clk` rising edge.
